// File: rtl/serial_digit_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the serial digit adder:
//   state_t    - controller states (IDLE, RUN, DONE)
//   idx_width  - width of a counter that must count 0 .. n-1 (at least 1 bit)
//   cfg_ok     - elaboration-time legality of a WIDTH/DIGIT pair
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-step operation still needs a 1-bit index so the port of the
  // counter never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The operand must split into a whole number of non-empty digits.
  function automatic bit cfg_ok(input int width, input int digit);
    return (digit >= 1) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit.sv
// -----------------------------------------------------------------------------
// full_adder / digit_adder
//
// digit_adder is the single arithmetic slice of the serial adder: a purely
// combinational DIGIT-bit ripple chain of full_adder cells.
//
// digit_adder ports:
//   a, b  [DIGIT]  digit operands
//   cin            carry into bit 0
//   sum   [DIGIT]  digit sum
//   cout           carry out of the top bit
//   cmsb           carry into the top bit (for two's-complement overflow)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  // c[i] is the carry into bit i; c[DIGIT] leaves the slice.
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// -----------------------------------------------------------------------------
// serial_digit_adder
//
// Handshaked add/subtract unit that walks a WIDTH-bit operand pair through a
// single DIGIT-bit ripple slice, least-significant digit first, holding the
// carry in a flop between digits. N = WIDTH/DIGIT edges per operation.
//
// Ports:
//   clock             rising-edge clock
//   reset             synchronous, active-high
//   start             request; taken only on an edge where ready = 1
//   sub               0: p + q, 1: p - q (sampled with start)
//   p, q   [WIDTH]    operands (sampled with start)
//   ready             unit can accept start this cycle (IDLE or DONE)
//   done              one-cycle pulse: result/overflow were just updated
//   result [WIDTH+1]  {carry-out, sum}; for sub, bit WIDTH = 1 means no borrow
//   overflow          two's-complement overflow of the WIDTH-bit sum
// -----------------------------------------------------------------------------
module serial_digit_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic             ready,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = idx_width(N);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_error
    $error("serial_digit_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;

  logic [WIDTH-1:0] op_p;     // operand A, shifted right one digit per step
  logic [WIDTH-1:0] op_q;     // operand B (already inverted for sub), shifted
  logic [WIDTH-1:0] shadow;   // sum digits enter at the top, shift down
  logic             carry;
  logic [IW-1:0]    idx;

  // ---------------------------------------------------------------------------
  // Datapath slice
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (op_p[DIGIT-1:0]),
    .b    (op_q[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // Shadow after this step: new digit on top, everything else one digit down.
  // Concatenate-then-select keeps this legal when DIGIT equals WIDTH.
  logic [WIDTH+DIGIT-1:0] shadow_cat;
  logic [WIDTH-1:0]       shadow_nx;

  assign shadow_cat = {dsum, shadow};
  assign shadow_nx  = shadow_cat[WIDTH+DIGIT-1:DIGIT];

  logic accept;
  logic last_digit;

  assign ready      = (state_q != RUN);
  assign done       = (state_q == DONE);
  assign accept     = start && ready;
  assign last_digit = (state_q == RUN) && (idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its hold value before the case so no path through this
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)      state_d = RUN;
      RUN:  if (last_digit) state_d = DONE;
      DONE: state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, shadow, carry, index and output registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand and shadow registers are reset along with everything
  // else; they are few flops, and it keeps a mid-run reset from leaving any
  // trace of the discarded operation in simulation or in X-propagation.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_p     <= '0;
      op_q     <= '0;
      shadow   <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtraction is p + ~q + 1: invert q here and seed the carry with 1.
      op_p  <= p;
      op_q  <= sub ? ~q : q;
      carry <= sub;
      idx   <= '0;
    end else if (state_q == RUN) begin
      op_p   <= op_p >> DIGIT;
      op_q   <= op_q >> DIGIT;
      shadow <= shadow_nx;
      carry  <= dcout;
      idx    <= idx + IW'(1);
      if (last_digit) begin
        result   <= {dcout, shadow_nx};
        overflow <= dcmsb ^ dcout;
      end
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_digit_adder
//
// Directed scenarios on a WIDTH=16 / DIGIT=4 instance (N = 4), followed by a
// random sweep that runs the same operations through DIGIT = 1, 4 and 16
// instances against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_serial_digit_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start1, start4, start16;
  logic         sub;
  logic [W-1:0] p, q;

  logic         ready1, ready4, ready16;
  logic         done1, done4, done16;
  logic [W:0]   result1, result4, result16;
  logic         ov1, ov4, ov16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(W), .DIGIT(4)) dut (
    .clock (clk), .reset (reset), .start (start4), .sub (sub), .p (p), .q (q),
    .ready (ready4), .done (done4), .result (result4), .overflow (ov4)
  );

  serial_digit_adder #(.WIDTH(W), .DIGIT(1)) dut_d1 (
    .clock (clk), .reset (reset), .start (start1), .sub (sub), .p (p), .q (q),
    .ready (ready1), .done (done1), .result (result1), .overflow (ov1)
  );

  serial_digit_adder #(.WIDTH(W), .DIGIT(16)) dut_d16 (
    .clock (clk), .reset (reset), .start (start16), .sub (sub), .p (p), .q (q),
    .ready (ready16), .done (done16), .result (result16), .overflow (ov16)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the N=4 unit ready: present operands, take E0.
  task automatic issue4(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    p = a; q = b; sub = s; start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // Counts edges after E0 until done, and cycles seen with ready low.
  task automatic wait_done4(output int edges, output int low);
    edges = 0;
    low   = 0;
    while (!done4 && edges < 12) begin
      if (!ready4) low++;
      tick();
      edges++;
    end
  endtask

  task automatic check_op4(input string name, input int edges, input int low,
                           input logic [W:0] exp_r, input logic exp_ov);
    checks++;
    if (done4 !== 1'b1 || edges !== 4) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d edges, expected done=1 after 4", name, done4, edges);
    end
    checks++;
    if (low !== 4 || ready4 !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: low for %0d cycles, ready in DONE=%b, expected 4 and 1", name, low, ready4);
    end
    checks++;
    if (result4 !== exp_r || ov4 !== exp_ov) begin
      errors++;
      $display("FAIL %s result: got %05h ov=%b, expected %05h ov=%b", name, result4, ov4, exp_r, exp_ov);
    end
  endtask

  task automatic run_op4(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s,
                         input logic [W:0] exp_r, input logic exp_ov);
    int edges, low;
    issue4(a, b, s);
    wait_done4(edges, low);
    check_op4(name, edges, low, exp_r, exp_ov);
    tick();  // leave DONE for IDLE
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    sub = 1'b0; p = '0; q = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0 || result4 !== 17'h00000 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b result=%05h ov=%b, expected 1 0 00000 0", ready4, done4, result4, ov4);
    end
    checks++;
    if (ready1 !== 1'b1 || ready16 !== 1'b1 || done1 !== 1'b0 || done16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_other_widths: ready1=%b ready16=%b done1=%b done16=%b, expected 1 1 0 0", ready1, ready16, done1, done16);
    end
  endtask

  task automatic test_add();
    run_op4("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    run_op4("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
    run_op4("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
  endtask

  task automatic test_sub();
    run_op4("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 17'h0FFFE, 1'b0);
    run_op4("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 17'h17FFF, 1'b1);
  endtask

  task automatic test_ignore_start();
    int edges, low;
    issue4(16'h1234, 16'h4321, 1'b0);
    tick();
    // Second RUN cycle: a fresh request must be dropped entirely.
    p = 16'hAAAA; q = 16'h1111; sub = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done4(edges, low);
    check_op4("ignore_start", edges + 2, low + 2, 17'h05555, 1'b0);
    tick();
    checks++;
    if (done4 !== 1'b0 || ready4 !== 1'b1) begin
      errors++;
      $display("FAIL ignore_no_queue: done=%b ready=%b, expected 0 1", done4, ready4);
    end
  endtask

  task automatic test_back_to_back();
    int edges, low;
    issue4(16'h0010, 16'h0020, 1'b0);
    wait_done4(edges, low);
    check_op4("b2b_first", edges, low, 17'h00030, 1'b0);
    // Start held in the DONE cycle is accepted straight into RUN.
    issue4(16'h0100, 16'h0001, 1'b1);
    wait_done4(edges, low);
    check_op4("b2b_second", edges, low, 17'h100FF, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_run();
    issue4(16'h1234, 16'h4321, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0 || result4 !== 17'h00000 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: ready=%b done=%b result=%05h ov=%b, expected 1 0 00000 0", ready4, done4, result4, ov4);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done4 !== 1'b0 || result4 !== 17'h00000) begin
        errors++;
        $display("FAIL mid_run_discard: cycle %0d done=%b result=%05h, expected 0 00000", i, done4, result4);
      end
    end
    run_op4("post_reset_add", 16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0);
  endtask

  task automatic test_sweep();
    logic [W:0] exp_r;
    logic       exp_ov;
    logic       got1, got4, got16;
    int         r;
    for (int n = 0; n < 1000; n++) begin
      r   = $urandom;
      p   = r[W-1:0];
      r   = $urandom;
      q   = r[W-1:0];
      sub = 1'($urandom_range(0, 1));
      if (sub) exp_r = {1'b0, p} + {1'b0, ~q} + 17'd1;
      else     exp_r = {1'b0, p} + {1'b0, q};
      exp_ov = sub ? ((p[W-1] != q[W-1]) && (exp_r[W-1] != p[W-1]))
                   : ((p[W-1] == q[W-1]) && (exp_r[W-1] != p[W-1]));
      start1 = 1'b1; start4 = 1'b1; start16 = 1'b1;
      tick();
      start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
      got1 = 1'b0; got4 = 1'b0; got16 = 1'b0;
      for (int cyc = 1; cyc <= 17; cyc++) begin
        tick();
        if (done1 && !got1) begin
          got1 = 1'b1;
          checks++;
          if (result1 !== exp_r || ov1 !== exp_ov || cyc !== 16) begin
            errors++;
            $display("FAIL sweep_d1 op %0d: got %05h ov=%b at %0d edges, expected %05h ov=%b at 16", n, result1, ov1, cyc, exp_r, exp_ov);
          end
        end
        if (done4 && !got4) begin
          got4 = 1'b1;
          checks++;
          if (result4 !== exp_r || ov4 !== exp_ov || cyc !== 4) begin
            errors++;
            $display("FAIL sweep_d4 op %0d: got %05h ov=%b at %0d edges, expected %05h ov=%b at 4", n, result4, ov4, cyc, exp_r, exp_ov);
          end
        end
        if (done16 && !got16) begin
          got16 = 1'b1;
          checks++;
          if (result16 !== exp_r || ov16 !== exp_ov || cyc !== 1) begin
            errors++;
            $display("FAIL sweep_d16 op %0d: got %05h ov=%b at %0d edges, expected %05h ov=%b at 1", n, result16, ov16, cyc, exp_r, exp_ov);
          end
        end
      end
      checks++;
      if (!(got1 && got4 && got16)) begin
        errors++;
        $display("FAIL sweep_timeout op %0d: done seen d1=%b d4=%b d16=%b, expected 1 1 1", n, got1, got4, got16);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
